// File: rtl/pcileech_cfgrd_pkg.sv
// Shared widths and types for the shadow config-space read arbiter.
package pcileech_cfgrd_pkg;

    localparam int unsigned CFG_ADDR_W = 10;
    localparam int unsigned CFG_DATA_W = 32;
    localparam int unsigned CNT_W      = 16;

    typedef logic [CFG_ADDR_W-1:0] cfg_addr_t;
    typedef logic [CFG_DATA_W-1:0] cfg_data_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/pcileech_rr_pick.sv
// Combinational one-hot round-robin pick: the first requester after ptr wins.
module pcileech_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant
);

    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] ptr_bit;
    logic [N-1:0] upto_ptr;
    logic [N-1:0] masked;
    logic [N-1:0] pool;

    always_comb begin
        // Requests strictly above ptr are searched first; if none, wrap to bit 0.
        // When ptr is the top bit the shift overflows to zero and the mask becomes all ones.
        ptr_bit  = ONE_N << ptr;
        upto_ptr = (ptr_bit << 1) - ONE_N;
        masked   = req & ~upto_ptr;
        pool     = (masked != '0) ? masked : req;
        grant    = pool & (~pool + ONE_N);
    end

endmodule

// File: rtl/pcileech_cfgrd_arbiter.sv
// Round-robin arbiter sharing one shadow config read port among NUM_REQ requesters.
// Define PCILEECH_CFGRD_ARB_PRIO0_EN to give requester 0 strict priority.
module pcileech_cfgrd_arbiter
    import pcileech_cfgrd_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*CFG_ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          cfg_rden,
    output logic [CFG_ADDR_W-1:0]         cfg_rd_addr,
    input  logic [CFG_DATA_W-1:0]         cfg_rd_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [CFG_DATA_W-1:0]         rsp_data,
    output logic [CNT_W-1:0]              contention_cnt
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_R = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [PW-1:0]      last_grant;
    logic [NUM_REQ-1:0] rr_grant;
    logic [NUM_REQ-1:0] grant;
    logic               prio0_win;
    logic               accept;
    logic [PW-1:0]      grant_idx;
    cfg_addr_t          grant_addr;
    logic               contended;

    // tag_sr[k] holds the one-hot owner of the read issued k+1 cycles after its accept
    logic [RD_LATENCY:0][NUM_REQ-1:0] tag_sr;

    pcileech_rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .ptr   (last_grant),
        .req   (req_valid),
        .grant (rr_grant)
    );

`ifdef PCILEECH_CFGRD_ARB_PRIO0_EN
    always_comb begin
        prio0_win = req_valid[0];
        grant     = prio0_win ? ONE_R : rr_grant;
    end
`else
    always_comb begin
        prio0_win = 1'b0;
        grant     = rr_grant;
    end
`endif

    always_comb begin
        req_ready = rst ? '0 : grant;
        accept    = |req_ready;
        contended = (req_valid & (req_valid - ONE_R)) != '0;
    end

    always_comb begin
        grant_idx  = '0;
        grant_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx  = PW'(i);
                grant_addr = req_addr[i*CFG_ADDR_W +: CFG_ADDR_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant     <= PW'(NUM_REQ - 1);
            cfg_rden       <= 1'b0;
            cfg_rd_addr    <= '0;
            tag_sr         <= '0;
            rsp_valid      <= '0;
            rsp_data       <= '0;
            contention_cnt <= '0;
        end else begin
            cfg_rden <= accept;
            if (accept) begin
                cfg_rd_addr <= grant_addr;
                if (!prio0_win) begin
                    last_grant <= grant_idx;
                end
            end
            tag_sr    <= {tag_sr[RD_LATENCY-1:0], req_ready};
            rsp_valid <= tag_sr[RD_LATENCY];
            if (|tag_sr[RD_LATENCY]) begin
                rsp_data <= cfg_rd_data;
            end
            if (contended && contention_cnt != CNT_MAX) begin
                contention_cnt <= contention_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pcileech_cfgrd_arbiter.sv
// Self-checking bench for pcileech_cfgrd_arbiter against a queue-based reference model.
module tb_pcileech_cfgrd_arbiter;

    localparam int N = 4;
    localparam int L = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*10-1:0] req_addr = '0;
    logic [N-1:0]    req_ready;
    logic            cfg_rden;
    logic [9:0]      cfg_rd_addr;
    logic [31:0]     cfg_rd_data;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_data;
    logic [15:0]     contention_cnt;

    int vectors = 0;
    int miscompares = 0;

    pcileech_cfgrd_arbiter #(
        .NUM_REQ    (N),
        .RD_LATENCY (L)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .cfg_rden       (cfg_rden),
        .cfg_rd_addr    (cfg_rd_addr),
        .cfg_rd_data    (cfg_rd_data),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .contention_cnt (contention_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return 32'h8000_0001 + {22'h0, a};
    endfunction

    // Shadow config memory: data for the address read in cycle c is valid in cycle c+L.
    logic [31:0] mem_pipe [L];
    always @(posedge clk) begin
        mem_pipe[0] <= mem_word(cfg_rd_addr);
        for (int k = 1; k < L; k++) mem_pipe[k] <= mem_pipe[k-1];
    end
    assign cfg_rd_data = mem_pipe[L-1];

    // Reference model
    typedef struct {
        int          due;
        int          idx;
        logic [31:0] data;
    } pend_t;

    pend_t       pend[$];
    int          m_lg = N - 1;
    int          m_cnt = 0;
    int          m_cyc = 0;
    logic        m_rden = 1'b0;
    logic [9:0]  m_addr = '0;
    logic [N-1:0] m_rsp_v = '0;
    logic [31:0] m_rsp_d = '0;

    function automatic int pick(input int lg, input logic [N-1:0] v);
        logic [N-1:0] t;
`ifdef PCILEECH_CFGRD_ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            t = v >> ((lg + k) % N);
            if (t[0]) return (lg + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = pick(m_lg, req_valid);
        if (!rst && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        int g;
        if (rst) begin
            m_lg = N - 1; m_cnt = 0; m_rden = 1'b0; m_addr = '0;
            m_rsp_v = '0; m_rsp_d = '0;
            pend.delete();
        end else begin
            g = pick(m_lg, req_valid);
            m_rden = (g >= 0);
            if (g >= 0) begin
                m_addr = req_addr[g*10 +: 10];
                pend.push_back('{m_cyc + L + 2, g, mem_word(m_addr)});
`ifdef PCILEECH_CFGRD_ARB_PRIO0_EN
                if (!req_valid[0]) m_lg = g;
`else
                m_lg = g;
`endif
            end
            if ($countones(req_valid) >= 2 && m_cnt < 65535) m_cnt++;
            m_cyc++;
            m_rsp_v = '0;
            if (pend.size() > 0 && pend[0].due == m_cyc) begin
                m_rsp_v[pend[0].idx] = 1'b1;
                m_rsp_d = pend[0].data;
                void'(pend.pop_front());
            end
        end
    end

    task automatic apply_reset();
        req_valid = '0;
        req_addr  = '0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = '0;
        @(posedge clk); #1 rst = 1'b1;
        req_valid = '1;
        req_addr  = 40'($urandom);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== '0) begin miscompares++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
            vectors++;
            if ({cfg_rden, cfg_rd_addr, rsp_valid, rsp_data, contention_cnt} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: rden %b addr %h rspv %b rspd %h cnt %h exp all 0",
                         cfg_rden, cfg_rd_addr, rsp_valid, rsp_data, contention_cnt);
            end
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL reset_first_grant: got %b exp 0001", req_ready); end
    endtask

    task automatic test_single();
        apply_reset();
        req_valid = 4'b0001;
        req_addr  = '0;
        req_addr[9:0] = 10'h010;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL single_accept: got %b exp 0001", req_ready); end
        @(posedge clk); #1 req_valid = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
            if (cfg_rden !== (k == 1)) begin miscompares++; $display("FAIL single_rden T+%0d: got %b exp %b", k, cfg_rden, k == 1); end
            if (k == 1) begin
                vectors++;
                if (cfg_rd_addr !== 10'h010) begin miscompares++; $display("FAIL single_addr: got %h exp 010", cfg_rd_addr); end
            end
            vectors++;
            if (rsp_valid !== ((k == 4) ? 4'b0001 : 4'b0000)) begin
                miscompares++; $display("FAIL single_rspv T+%0d: got %b", k, rsp_valid);
            end
            if (k >= 4) begin
                vectors++;
                if (rsp_data !== 32'h8000_0011) begin miscompares++; $display("FAIL single_data T+%0d: got %h exp 80000011", k, rsp_data); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_all_four();
        logic [N-1:0] exp_r;
        apply_reset();
        req_valid = '1;
        req_addr  = {10'h3A3, 10'h2B2, 10'h1C1, 10'h0D0};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
`ifdef PCILEECH_CFGRD_ARB_PRIO0_EN
            exp_r = 4'b0001;
`else
            exp_r = 4'b0001 << (c % 4);
`endif
            vectors++;
            if (req_ready !== exp_r) begin miscompares++; $display("FAIL all4_order c%0d: got %b exp %b", c, req_ready, exp_r); end
            vectors++;
            if (cfg_rden !== (c >= 1)) begin miscompares++; $display("FAIL all4_rden c%0d: got %b exp %b", c, cfg_rden, c >= 1); end
            vectors++;
            if (contention_cnt !== 16'(c)) begin miscompares++; $display("FAIL all4_cnt c%0d: got %0d exp %0d", c, contention_cnt, c); end
            vectors++;
            if (rsp_valid !== m_rsp_v || (m_rsp_v != '0 && rsp_data !== m_rsp_d)) begin
                miscompares++; $display("FAIL all4_rsp c%0d: got %b/%h exp %b/%h", c, rsp_valid, rsp_data, m_rsp_v, m_rsp_d);
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== m_rsp_v || rsp_data !== m_rsp_d) begin
                miscompares++; $display("FAIL all4_drain c%0d: got %b/%h exp %b/%h", c, rsp_valid, rsp_data, m_rsp_v, m_rsp_d);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] exp_v;
        apply_reset();
        repeat (5) @(posedge clk);
        #1 req_valid = 4'b0100;
        req_addr = '0;
        req_addr[29:20] = 10'h001;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j < 3) begin
                vectors++;
                if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL b2b_accept j%0d: got %b exp 0100", j, req_ready); end
            end
            exp_v = (j >= 4 && j <= 6) ? 4'b0100 : 4'b0000;
            vectors++;
            if (rsp_valid !== exp_v) begin miscompares++; $display("FAIL b2b_rspv j%0d: got %b exp %b", j, rsp_valid, exp_v); end
            if (j >= 4 && j <= 6) begin
                vectors++;
                if (rsp_data !== 32'h8000_0001 + 32'(j - 3)) begin
                    miscompares++; $display("FAIL b2b_data j%0d: got %h exp %h", j, rsp_data, 32'h8000_0001 + 32'(j - 3));
                end
            end
            @(posedge clk); #1;
            if (j < 2) req_addr[29:20] = 10'(j + 2);
            else req_valid = '0;
        end
    endtask

    task automatic test_drop();
        int rden_seen;
        logic rsp1_seen;
        apply_reset();
        req_valid = 4'b0011;
        req_addr  = {10'h0, 10'h0, 10'h155, 10'h0AA};
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL drop_first: got %b exp 0001", req_ready); end
        @(posedge clk); #1 req_valid = '0;
        rden_seen = 0;
        rsp1_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (cfg_rden) rden_seen++;
            if (rsp_valid[1]) rsp1_seen = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if (rden_seen !== 1) begin miscompares++; $display("FAIL drop_reads: got %0d exp 1", rden_seen); end
        vectors++;
        if (rsp1_seen !== 1'b0) begin miscompares++; $display("FAIL drop_rsp1: got %b exp 0", rsp1_seen); end
    endtask

    task automatic test_reset_midflight();
        logic any_rsp;
        apply_reset();
        req_valid = 4'b0010;
        req_addr  = {10'h0, 10'h0, 10'h2EE, 10'h0};
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL mid_accept: got %b exp 0010", req_ready); end
        @(posedge clk); #1 req_valid = '0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        any_rsp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) any_rsp = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if (any_rsp !== 1'b0) begin miscompares++; $display("FAIL mid_no_rsp: got %b exp 0", any_rsp); end
        req_valid = '1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL mid_first_grant: got %b exp 0001", req_ready); end
        @(posedge clk); #1 req_valid = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            er = exp_ready();
            vectors++;
            if (req_ready !== er) begin miscompares++; $display("FAIL rnd_ready c%0d: got %b exp %b", c, req_ready, er); end
            vectors++;
            if (cfg_rden !== m_rden || cfg_rd_addr !== m_addr) begin
                miscompares++; $display("FAIL rnd_cfg c%0d: got %b/%h exp %b/%h", c, cfg_rden, cfg_rd_addr, m_rden, m_addr);
            end
            vectors++;
            if (rsp_valid !== m_rsp_v || rsp_data !== m_rsp_d) begin
                miscompares++; $display("FAIL rnd_rsp c%0d: got %b/%h exp %b/%h", c, rsp_valid, rsp_data, m_rsp_v, m_rsp_d);
            end
            vectors++;
            if (contention_cnt !== 16'(m_cnt)) begin miscompares++; $display("FAIL rnd_cnt c%0d: got %0d exp %0d", c, contention_cnt, m_cnt); end
            @(posedge clk); #1;
            rst = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || er[i]) begin
                    req_valid[i] = ($urandom_range(0, 99) < 55);
                    req_addr[i*10 +: 10] = 10'($urandom);
                end else if ($urandom_range(0, 99) < 5) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_saturation();
        apply_reset();
        req_valid = '1;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (contention_cnt !== 16'hFFFE) begin miscompares++; $display("FAIL sat_pre: got %h exp FFFE", contention_cnt); end
        @(negedge clk);
        vectors++;
        if (contention_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hit: got %h exp FFFF", contention_cnt); end
        repeat (5) @(negedge clk);
        vectors++;
        if (contention_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold: got %h exp FFFF", contention_cnt); end
        @(posedge clk); #1 req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_back_to_back();
        test_drop();
        test_reset_midflight();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
